// File: rtl/mult_seq_ctrl_if.sv
// Pipeline-side bundle of the multiply sequencer:
// issue request, operands, flush and the result strobe.
interface mult_seq_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic [63:0] result;
  logic        hilo_we;
  logic        gpr_we;

  modport master (
    output start, op, operand_1, operand_2,
    output hi_in, lo_in, flush,
    input  stall_req, done, result,
    input  hilo_we, gpr_we
  );

  modport slave (
    input  start, op, operand_1, operand_2,
    input  hi_in, lo_in, flush,
    output stall_req, done, result,
    output hilo_we, gpr_we
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// EX-stage sequencer for the shared combinational multiplier:
// holds operands, waits LATENCY cycles, optionally accumulates.
module mult_seq_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  mult_seq_ctrl_if.slave bus,
  output logic           mult_signed,
  output logic [31:0]    mult_op1,
  output logic [31:0]    mult_op2,
  input  logic [63:0]    mult_result
);

  typedef enum logic [1:0] {
    IDLE, BUSY, ACC, DONE
  } state_e;

  localparam logic [3:0] CntLast = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        sgn_q, sgn_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [63:0] hilo_q, hilo_d;
  logic [63:0] prod_q, prod_d;
  logic [63:0] res_q, res_d;
  logic        done_q, done_d;
  logic        hwe_q, hwe_d;
  logic        gwe_q, gwe_d;
  logic        stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    hilo_d  = hilo_q;
    prod_d  = prod_q;
    res_d   = res_q;
    done_d  = 1'b0;
    hwe_d   = 1'b0;
    gwe_d   = 1'b0;
    stall   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          stall   = 1'b1;
          op_d    = bus.op;
          sgn_d   = ~bus.op[0];
          op1_d   = bus.operand_1;
          op2_d   = bus.operand_2;
          hilo_d  = {bus.hi_in, bus.lo_in};
          cnt_d   = 4'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CntLast) begin
          prod_d = mult_result;
          if (!op_q[2]) begin
            res_d = mult_result;
          end
          state_d = op_q[2] ? ACC : DONE;
        end
      end
      ACC: begin
        stall   = 1'b1;
        res_d   = op_q[1] ? hilo_q - prod_q
                          : hilo_q + prod_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d = IDLE;
    end

    // strobes are registered, so they follow the state being entered
    if (state_d == DONE) begin
      done_d = 1'b1;
      hwe_d  = (op_q != 3'b010) && (op_q != 3'b011);
      gwe_d  = (op_q == 3'b010);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      sgn_q   <= 1'b0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      hilo_q  <= 64'd0;
      prod_q  <= 64'd0;
      res_q   <= 64'd0;
      done_q  <= 1'b0;
      hwe_q   <= 1'b0;
      gwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      hilo_q  <= hilo_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      done_q  <= done_d;
      hwe_q   <= hwe_d;
      gwe_q   <= gwe_d;
    end
  end

  assign bus.stall_req = stall;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.hilo_we   = hwe_q;
  assign bus.gpr_we    = gwe_q;
  assign mult_signed   = sgn_q;
  assign mult_op1      = op1_q;
  assign mult_op2      = op2_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: LATENCY=2 and LATENCY=1 instances,
// scoreboard queues checked by done-driven monitors.
module tb_mult_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic [31:0] hi = 32'd0;
  logic [31:0] lo = 32'd0;

  always #5 clk = ~clk;

  mult_seq_ctrl_if bus_a ();
  mult_seq_ctrl_if bus_b ();

  assign bus_a.start     = start_a;
  assign bus_a.op        = op;
  assign bus_a.operand_1 = opa;
  assign bus_a.operand_2 = opb;
  assign bus_a.hi_in     = hi;
  assign bus_a.lo_in     = lo;
  assign bus_a.flush     = flush;
  assign bus_b.start     = start_b;
  assign bus_b.op        = op;
  assign bus_b.operand_1 = opa;
  assign bus_b.operand_2 = opb;
  assign bus_b.hi_in     = hi;
  assign bus_b.lo_in     = lo;
  assign bus_b.flush     = flush;

  logic        sg_a, sg_b;
  logic [31:0] m1_a, m2_a, m1_b, m2_b;
  logic [63:0] p_a, p_b;

  function automatic logic [63:0] mul64(
    input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'd0, a};
    xb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return xa * xb;
  endfunction

  assign p_a = mul64(sg_a, m1_a, m2_a);
  assign p_b = mul64(sg_b, m1_b, m2_b);

  mult_seq_ctrl #(.LATENCY(2)) u_a (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_a),
    .mult_signed (sg_a),
    .mult_op1    (m1_a),
    .mult_op2    (m2_a),
    .mult_result (p_a)
  );

  mult_seq_ctrl #(.LATENCY(1)) u_b (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_b),
    .mult_signed (sg_b),
    .mult_op1    (m1_b),
    .mult_op2    (m2_b),
    .mult_result (p_b)
  );

  int checks = 0;
  int errors = 0;
  logic [65:0] qa[$];
  logic [65:0] qb[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic stall_of(input int inst);
    return (inst == 0) ? bus_a.stall_req : bus_b.stall_req;
  endfunction

  function automatic logic done_of(input int inst);
    return (inst == 0) ? bus_a.done : bus_b.done;
  endfunction

  function automatic logic sgn_of(input int inst);
    return (inst == 0) ? sg_a : sg_b;
  endfunction

  // monitors: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus_a.done === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL done_a: unexpected done, result %h",
                 bus_a.result);
      end else begin
        logic [65:0] e;
        e = qa.pop_front();
        if ({bus_a.result, bus_a.hilo_we, bus_a.gpr_we} !== e) begin
          errors++;
          $display("FAIL result_a: got %h/%b/%b expected %h/%b/%b",
                   bus_a.result, bus_a.hilo_we, bus_a.gpr_we,
                   e[65:2], e[1], e[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.done === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL done_b: unexpected done, result %h",
                 bus_b.result);
      end else begin
        logic [65:0] e;
        e = qb.pop_front();
        if ({bus_b.result, bus_b.hilo_we, bus_b.gpr_we} !== e) begin
          errors++;
          $display("FAIL result_b: got %h/%b/%b expected %h/%b/%b",
                   bus_b.result, bus_b.hilo_we, bus_b.gpr_we,
                   e[65:2], e[1], e[0]);
        end
      end
    end
  end

  // Issue one op in the cycle after the call; lat = cycles to done.
  task automatic run(input int inst, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] h, input logic [31:0] l,
                     input logic [63:0] er, input logic hw,
                     input logic gw, input int lat, input logic es);
    if (inst == 0) qa.push_back({er, hw, gw});
    else qb.push_back({er, hw, gw});
    @(posedge clk); #1;
    op = o; opa = a; opb = b; hi = h; lo = l;
    if (inst == 0) start_a = 1'b1;
    else start_b = 1'b1;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("stall_i%0d_op%0d_k%0d", inst, o, k),
          stall_of(inst), (k < lat));
      chk($sformatf("done_i%0d_op%0d_k%0d", inst, o, k),
          done_of(inst), (k == lat));
      if (k < lat) begin
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        opa = 32'hDEAD_BEEF; opb = 32'h1234_5678;
        hi = 32'hCAFE_F00D; lo = 32'h0BAD_0BAD;
      end
    end
    chk($sformatf("signed_i%0d_op%0d", inst, o), sgn_of(inst), es);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", bus_a.stall_req, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_result", bus_a.result, 0);
    chk("rst_op1", m1_a, 0);
    chk("rst_signed", sg_a, 0);
    chk("rst_we", {bus_a.hilo_we, bus_a.gpr_we}, 0);
    rst = 1'b0;

    run(0, 3'b000, 32'hFFFF_FFFE, 32'd3, 0, 0,
        64'hFFFF_FFFF_FFFF_FFFA, 1, 0, 3, 1);
    run(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
        64'hFFFF_FFFE_0000_0001, 1, 0, 3, 0);
    run(0, 3'b010, 32'd7, 32'hFFFF_FFFF, 0, 0,
        64'hFFFF_FFFF_FFFF_FFF9, 0, 1, 3, 1);
    run(0, 3'b100, 32'd2, 32'd3, 32'd0, 32'd5,
        64'h0000_0000_0000_000B, 1, 0, 4, 1);
    run(0, 3'b111, 32'd1, 32'd1, 32'd0, 32'd0,
        64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 4, 0);
    run(0, 3'b110, 32'd2, 32'd3, 32'd0, 32'd10,
        64'h0000_0000_0000_0004, 1, 0, 4, 1);
    run(0, 3'b101, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1,
        64'h0000_0001_FFFF_FFFF, 1, 0, 4, 0);
    run(0, 3'b011, 32'd3, 32'd4, 0, 0,
        64'h0000_0000_0000_000C, 0, 0, 3, 0);

    // flush while BUSY: no done may follow
    @(posedge clk); #1;
    op = 3'b000; opa = 32'd5; opb = 32'd5; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_stall", bus_a.stall_req, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_stall", bus_a.stall_req, 0);
    chk("flush_done", bus_a.done, 0);
    chk("flush_we", {bus_a.hilo_we, bus_a.gpr_we}, 0);
    run(0, 3'b000, 32'd4, 32'd5, 0, 0,
        64'h0000_0000_0000_0014, 1, 0, 3, 1);

    // synchronous reset while in ACC
    @(posedge clk); #1;
    op = 3'b100; opa = 32'd3; opb = 32'd4;
    hi = 32'd1; lo = 32'd2; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("acc_stall", bus_a.stall_req, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("accrst_result", bus_a.result, 0);
    chk("accrst_done", bus_a.done, 0);
    chk("accrst_we", {bus_a.hilo_we, bus_a.gpr_we}, 0);
    chk("accrst_stall", bus_a.stall_req, 0);
    chk("accrst_ops", {m1_a, m2_a}, 0);
    chk("accrst_signed", sg_a, 0);

    run(1, 3'b000, 32'hFFFF_FFFE, 32'd3, 0, 0,
        64'hFFFF_FFFF_FFFF_FFFA, 1, 0, 2, 1);
    run(1, 3'b100, 32'd2, 32'd3, 32'd0, 32'd5,
        64'h0000_0000_0000_000B, 1, 0, 3, 1);

    repeat (3) @(negedge clk);
    chk("queue_a_empty", 64'(qa.size()), 0);
    chk("queue_b_empty", 64'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
